enc_conditioner: RTL and testbench
==================================

# enc_conditioner

Single-channel quadrature encoder front end between the raw `encN_a`/`encN_b` board pins and the RPM reader. It synchronises both phase inputs, rejects glitches with a persistence filter, and decodes the filtered Gray sequence. Outputs are a one-cycle step pulse, a direction flag, a wrapping signed position count and illegal-transition error reporting. The top level instantiates one per motor channel (four total).

## Interface
- `FILT_LEN`, 4: consecutive differing synchronised samples required before a filtered phase changes; legal range 2..15.
- `POS_WIDTH`, 16: width of the signed position counter.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `enc_a` in 1: raw encoder phase A, asynchronous to `clk`.
- `enc_b` in 1: raw encoder phase B, asynchronous to `clk`.
- `clr_pos` in 1: synchronous clear of `pos_o`, sampled every cycle.
- `enc_a_o` out 1: filtered phase A level.
- `enc_b_o` out 1: filtered phase B level.
- `step_o` out 1: one-cycle pulse per legal quadrature edge.
- `dir_o` out 1: direction of the most recent legal step (1 = forward, A leads B).
- `pos_o` out POS_WIDTH: signed two's-complement position in quadrature counts.
- `err_o` out 1: one-cycle pulse on an illegal transition.
- `err_cnt_o` out 8: saturating count of illegal transitions.

## Operation
- **Reset values.** Every output and internal register is 0 while `rst` is high. `rst` asserted mid-operation discards all in-flight filter and decode state on the next edge.
- **Synchroniser.** Two flip-flops per phase give `a_s` and `b_s`.
- **Filter, per phase.** A 4-bit counter `cnt` tracks how long the synchronised value has differed from the filtered value.
  - If the synchronised value equals the filtered value: `cnt` <= 0.
  - Else if `cnt` == FILT_LEN-1: filtered <= synchronised value, and `cnt` <= 0.
  - Else: `cnt` <= `cnt` + 1.
  - Net effect: any pulse shorter than FILT_LEN synchronised cycles is discarded.
- **Init phase.**
  - After `rst` deasserts, an init counter runs for 2+FILT_LEN cycles.
  - During init, the filtered values load the synchronised values directly every cycle, and the decoder is suppressed: no `step_o`, no `err_o`, no change to `pos_o`.
  - Purpose: no spurious step or error appears when the pins rest at a non-00 state.
- **Decoder.**
  - Register `prev` = filtered {A,B} delayed by one cycle.
  - Compare `cur` = filtered {A,B} against `prev`.
  - Forward sequence: 00→10→11→01→00.
  - Reverse sequence: 00→01→11→10→00.
  - `cur` == `prev`: no action.
  - Forward step: `step_o` = 1, `dir_o` <= 1, `pos_o` <= `pos_o` + 1.
  - Reverse step: `step_o` = 1, `dir_o` <= 0, `pos_o` <= `pos_o` - 1.
  - Both bits changed: `err_o` = 1, `err_cnt_o` <= min(`err_cnt_o` + 1, 255). `step_o`, `dir_o` and `pos_o` are unchanged.
- **Position arithmetic.** Wraps modulo 2^POS_WIDTH: 0x7FFF+1 gives 0x8000, and 0x0000-1 gives 0xFFFF.
- **`clr_pos`.**
  - `pos_o` <= 0 on the next edge.
  - A step coincident with `clr_pos`: clear wins for `pos_o`, while `step_o` and `dir_o` still update.
  - `clr_pos` does not affect `err_cnt_o`; only `rst` clears it.

## Timing
- **Pin to filtered output** (`enc_a_o`/`enc_b_o`): 2+FILT_LEN clock edges after the pin change is first sampled.
- **Pin to `step_o`/`err_o`/`pos_o` update:** 3+FILT_LEN edges. All three are registered and change on the same edge.
- **Pulse width:** `step_o` and `err_o` are high exactly one cycle per event. Back-to-back legal edges separated by ≥FILT_LEN cycles each produce a distinct pulse.
- **Maximum trackable edge rate:** one quadrature edge per FILT_LEN cycles. Faster edges are filtered away and are not reported as errors.
- **Handshake:** none. Downstream logic samples `step_o`/`pos_o` on any cycle.

## Test plan
1. **Reset at rest position.** Hold pins at A=1, B=1 through `rst`, then release. Required: `enc_a_o`=`enc_b_o`=1 after init, with `pos_o`=0, `err_cnt_o`=0, and no `step_o` pulse.
2. **Forward stepping.** Apply 8 forward quadrature edges spaced 10 cycles apart, with FILT_LEN=4. Required: 8 `step_o` pulses, each 7 edges after its pin change; `dir_o`=1; `pos_o`=8.
3. **Glitch rejection.**
   - A 3-cycle high glitch on A: no filtered change and no step.
   - A 4-cycle glitch on A: one forward step then one reverse step; `pos_o` returns to its prior value and `dir_o`=0.
4. **Illegal transition.** Toggle A and B on the same cycle from 00. Required: one `err_o` pulse, `err_cnt_o`=1, `pos_o` unchanged. Repeat 300 times: `err_cnt_o` saturates at 255.
5. **Wrap-around.**
   - Reverse step from `pos_o`=0: `pos_o`=0xFFFF, `dir_o`=0.
   - Preload to 0x7FFF by stepping, then one forward step: `pos_o`=0x8000.
6. **Clear coincident with step.** Assert `clr_pos` on the same edge a forward step lands, with `pos_o`=5. Required: `pos_o`=0, `step_o` pulses, `dir_o`=1. Separately, assert `rst` mid-filter: all outputs are 0 the next cycle.

Source files
------------

// File: rtl/enc_conditioner.sv
// Quadrature encoder front end: two-flop synchroniser and persistence filter per
// phase, a start-up init window, and a Gray-code decoder with position and error count.
module enc_conditioner #(
  parameter int FILT_LEN  = 4,
  parameter int POS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 clr_pos,
  output logic                 enc_a_o,
  output logic                 enc_b_o,
  output logic                 step_o,
  output logic                 dir_o,
  output logic [POS_WIDTH-1:0] pos_o,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  localparam logic [3:0]           CNT_MAX  = 4'(FILT_LEN - 1);
  localparam logic [4:0]           INIT_LEN = 5'(FILT_LEN + 2);
  localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

  typedef enum logic [1:0] {MV_NONE, MV_FWD, MV_REV, MV_ERR} move_e;

  logic                 a_meta_q, a_meta_d, a_sync_q, a_sync_d;
  logic                 b_meta_q, b_meta_d, b_sync_q, b_sync_d;
  logic                 a_filt_q, a_filt_d, b_filt_q, b_filt_d;
  logic [3:0]           a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [4:0]           init_cnt_q, init_cnt_d;
  logic [1:0]           prev_q, prev_d;
  logic                 step_q, step_d, dir_q, dir_d, err_q, err_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d, pos_nxt_s;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 init_active_s;
  move_e                move_s;

  // Returns {filtered, cnt}: a change is accepted only after FILT_LEN differing samples.
  function automatic logic [4:0] filt_step(input logic sync_v, input logic filt_v,
                                           input logic [3:0] cnt_v);
    logic [4:0] r;
    if (sync_v == filt_v) begin
      r = {filt_v, 4'd0};
    end else if (cnt_v == CNT_MAX) begin
      r = {sync_v, 4'd0};
    end else begin
      r = {filt_v, cnt_v + 4'd1};
    end
    return r;
  endfunction

  // State pairs are {A,B}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic move_e decode(input logic [1:0] p, input logic [1:0] c);
    move_e m;
    case ({p, c})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: m = MV_FWD;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: m = MV_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: m = MV_ERR;
      default:                            m = MV_NONE;
    endcase
    return m;
  endfunction

  assign init_active_s = (init_cnt_q != INIT_LEN);

  always_comb begin
    a_meta_d   = enc_a;
    a_sync_d   = a_meta_q;
    b_meta_d   = enc_b;
    b_sync_d   = b_meta_q;
    init_cnt_d = init_cnt_q;
    prev_d     = {a_filt_q, b_filt_q};
    move_s     = decode(prev_q, {a_filt_q, b_filt_q});
    // During init the filters track the pins directly so a resting non-00 state is silent.
    if (init_active_s) begin
      init_cnt_d = init_cnt_q + 5'd1;
      a_filt_d   = a_sync_q;
      a_cnt_d    = 4'd0;
      b_filt_d   = b_sync_q;
      b_cnt_d    = 4'd0;
      move_s     = MV_NONE;
    end else begin
      {a_filt_d, a_cnt_d} = filt_step(a_sync_q, a_filt_q, a_cnt_q);
      {b_filt_d, b_cnt_d} = filt_step(b_sync_q, b_filt_q, b_cnt_q);
    end

    step_d    = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir_q;
    pos_nxt_s = pos_q;
    err_cnt_d = err_cnt_q;
    case (move_s)
      MV_FWD: begin
        step_d    = 1'b1;
        dir_d     = 1'b1;
        pos_nxt_s = pos_q + POS_ONE;
      end
      MV_REV: begin
        step_d    = 1'b1;
        dir_d     = 1'b0;
        pos_nxt_s = pos_q - POS_ONE;
      end
      MV_ERR: begin
        err_d     = 1'b1;
        err_cnt_d = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
      end
      default: begin
        step_d = 1'b0;
      end
    endcase
    pos_d = clr_pos ? {POS_WIDTH{1'b0}} : pos_nxt_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_meta_q   <= 1'b0;
      a_sync_q   <= 1'b0;
      b_meta_q   <= 1'b0;
      b_sync_q   <= 1'b0;
      a_filt_q   <= 1'b0;
      b_filt_q   <= 1'b0;
      a_cnt_q    <= 4'd0;
      b_cnt_q    <= 4'd0;
      init_cnt_q <= 5'd0;
      prev_q     <= 2'b00;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= {POS_WIDTH{1'b0}};
      err_cnt_q  <= 8'd0;
    end else begin
      a_meta_q   <= a_meta_d;
      a_sync_q   <= a_sync_d;
      b_meta_q   <= b_meta_d;
      b_sync_q   <= b_sync_d;
      a_filt_q   <= a_filt_d;
      b_filt_q   <= b_filt_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign enc_a_o   = a_filt_q;
  assign enc_b_o   = b_filt_q;
  assign step_o    = step_q;
  assign dir_o     = dir_q;
  assign err_o     = err_q;
  assign pos_o     = pos_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_enc_conditioner.sv
// Bench for enc_conditioner: directed pin sequences, a cycle-level reference model
// checked every cycle, and hand-computed literal expectations per scenario.
module tb_enc_conditioner;

  localparam int FL   = 4;
  localparam int INIT = FL + 2;

  logic clk, rst, a, b, clr_pos;
  logic enc_a_o, enc_b_o, step_o, dir_o, err_o;
  logic [15:0] pos_o;
  logic [7:0]  err_cnt_o;
  logic e8a, e8b, s8, d8, r8;
  logic [7:0]  p8, c8;

  enc_conditioner #(.FILT_LEN(FL), .POS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enc_a(a), .enc_b(b), .clr_pos(clr_pos),
    .enc_a_o(enc_a_o), .enc_b_o(enc_b_o), .step_o(step_o), .dir_o(dir_o),
    .pos_o(pos_o), .err_o(err_o), .err_cnt_o(err_cnt_o));

  enc_conditioner #(.FILT_LEN(FL), .POS_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enc_a(a), .enc_b(b), .clr_pos(clr_pos),
    .enc_a_o(e8a), .enc_b_o(e8b), .step_o(s8), .dir_o(d8),
    .pos_o(p8), .err_o(r8), .err_cnt_o(c8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int step_seen = 0;
  int err_seen = 0;

  // Reference model state: filtered {A,B} now and one cycle earlier, plus outputs.
  logic [1:0]  m_f, m_p;
  logic        m_step, m_dir, m_err;
  logic [15:0] m_pos;
  logic [7:0]  m_ecnt;
  int          m_e;
  logic        qa[$], qb[$], ra[$], rb[$];

  function automatic int gidx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_edge();
    logic [1:0] old_f;
    logic sa, sb, flip;
    int d;
    if (rst) begin
      qa.delete(); qb.delete(); ra.delete(); rb.delete();
      m_f = 2'b00; m_p = 2'b00; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0;
      m_pos = 16'd0; m_ecnt = 8'd0; m_e = 0;
      return;
    end
    old_f = m_f;
    qa.push_back(a);
    qb.push_back(b);
    if (qa.size() > 3) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    sa = (qa.size() == 3) ? qa[0] : 1'b0;
    sb = (qb.size() == 3) ? qb[0] : 1'b0;
    if (m_e <= INIT) m_e++;
    m_step = 1'b0;
    m_err  = 1'b0;
    if (m_e <= INIT) begin
      m_f = {sa, sb};
      ra.delete(); rb.delete();
    end else begin
      // A phase flips once its last FL synchronised samples all disagree with it.
      ra.push_back(sa);
      if (ra.size() > FL) void'(ra.pop_front());
      flip = (ra.size() == FL);
      foreach (ra[i]) if (ra[i] == m_f[1]) flip = 1'b0;
      if (flip) begin m_f[1] = ~m_f[1]; ra.delete(); end
      rb.push_back(sb);
      if (rb.size() > FL) void'(rb.pop_front());
      flip = (rb.size() == FL);
      foreach (rb[i]) if (rb[i] == m_f[0]) flip = 1'b0;
      if (flip) begin m_f[0] = ~m_f[0]; rb.delete(); end
      d = (gidx(old_f) - gidx(m_p) + 4) % 4;
      if (d == 1) begin
        m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 16'd1;
      end else if (d == 3) begin
        m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 16'd1;
      end else if (d == 2) begin
        m_err = 1'b1;
        if (m_ecnt != 8'd255) m_ecnt = m_ecnt + 8'd1;
      end
    end
    if (clr_pos) m_pos = 16'd0;
    m_p = old_f;
  endtask

  task automatic compare();
    logic [49:0] act, exp;
    act = {enc_a_o, enc_b_o, step_o, dir_o, err_o, err_cnt_o, pos_o,
           e8a, e8b, s8, d8, r8, c8, p8};
    exp = {m_f, m_step, m_dir, m_err, m_ecnt, m_pos,
           m_f, m_step, m_dir, m_err, m_ecnt, m_pos[7:0]};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cycle_model t=%0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (step_o) step_seen++;
    if (err_o) err_seen++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input int n);
    a = s[1];
    b = s[0];
    repeat (n) tick();
  endtask

  initial begin
    logic [1:0] st;
    int lat;
    a = 1'b1; b = 1'b1; clr_pos = 1'b0; rst = 1'b1;
    m_f = 2'b00; m_p = 2'b00; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0;
    m_pos = 16'd0; m_ecnt = 8'd0; m_e = 0;

    // Reset with the pins resting at 11.
    repeat (3) tick();
    check("reset_outputs", 32'({enc_a_o, enc_b_o, step_o, dir_o, err_o}), 32'd0);
    rst = 1'b0;
    step_seen = 0;
    repeat (12) tick();
    check("init_filt_ab", 32'({enc_a_o, enc_b_o}), 32'd3);
    check("init_pos", 32'(pos_o), 32'd0);
    check("init_err_cnt", 32'(err_cnt_o), 32'd0);
    check("init_no_step", 32'(step_seen), 32'd0);

    // Eight forward edges, 10 cycles apart; the first one measures latency.
    st = fwd(2'b11);
    a = st[1]; b = st[0];
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step_o && lat == 0) lat = i;
    end
    check("step_latency", 32'(lat), 32'd7);
    for (int i = 0; i < 7; i++) begin
      st = fwd(st);
      drive(st, 10);
    end
    check("fwd_steps", 32'(step_seen), 32'd8);
    check("fwd_pos", 32'(pos_o), 32'd8);
    check("fwd_dir", 32'(dir_o), 32'd1);

    // Glitches on A from the 00 state.
    st = fwd(st); drive(st, 10);
    st = fwd(st); drive(st, 10);
    check("pre_glitch_pos", 32'(pos_o), 32'd10);
    step_seen = 0;
    a = 1'b1; repeat (3) tick();
    a = 1'b0; repeat (12) tick();
    check("glitch3_steps", 32'(step_seen), 32'd0);
    check("glitch3_pos", 32'(pos_o), 32'd10);
    a = 1'b1; repeat (4) tick();
    a = 1'b0; repeat (14) tick();
    check("glitch4_steps", 32'(step_seen), 32'd2);
    check("glitch4_pos", 32'(pos_o), 32'd10);
    check("glitch4_dir", 32'(dir_o), 32'd0);

    // Illegal transitions: both phases toggle together.
    err_seen = 0;
    st = 2'b11; drive(st, 10);
    check("illegal_err_pulses", 32'(err_seen), 32'd1);
    check("illegal_err_cnt", 32'(err_cnt_o), 32'd1);
    check("illegal_pos", 32'(pos_o), 32'd10);
    for (int i = 0; i < 299; i++) begin
      st = st ^ 2'b11;
      drive(st, 5);
    end
    repeat (10) tick();
    check("err_cnt_saturates", 32'(err_cnt_o), 32'd255);
    check("illegal_pos_kept", 32'(pos_o), 32'd10);

    // Wrap-around below zero, then across the signed midpoint of the 8-bit instance.
    clr_pos = 1'b1; tick(); clr_pos = 1'b0;
    repeat (3) tick();
    check("clr_pos", 32'(pos_o), 32'd0);
    st = 2'b01; drive(st, 10);
    check("wrap_neg_pos", 32'(pos_o), 32'h0000FFFF);
    check("wrap_neg_dir", 32'(dir_o), 32'd0);
    clr_pos = 1'b1; tick(); clr_pos = 1'b0;
    for (int i = 0; i < 127; i++) begin
      st = fwd(st);
      drive(st, 4);
    end
    repeat (8) tick();
    check("preload_pos8", 32'(p8), 32'h7F);
    check("preload_pos16", 32'(pos_o), 32'h007F);
    st = fwd(st); drive(st, 10);
    check("wrap_pos8", 32'(p8), 32'h80);
    check("wrap_pos16", 32'(pos_o), 32'h0080);

    // Clear landing on the same edge as a forward step.
    clr_pos = 1'b1; tick(); clr_pos = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st = fwd(st);
      drive(st, 10);
    end
    check("pre_clr_pos", 32'(pos_o), 32'd5);
    st = fwd(st);
    drive(st, 6);
    clr_pos = 1'b1; tick(); clr_pos = 1'b0;
    check("clr_step_pos", 32'(pos_o), 32'd0);
    check("clr_step_pulse", 32'(step_o), 32'd1);
    check("clr_step_dir", 32'(dir_o), 32'd1);
    repeat (10) tick();

    // Reset in the middle of a filter run.
    a = ~a;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_flags", 32'({enc_a_o, enc_b_o, step_o, dir_o, err_o}), 32'd0);
    check("midrst_pos", 32'(pos_o), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt_o), 32'd0);
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
